// File: rtl/cpu_xfer_pkg.sv
// Shared definitions for the register-transfer controller: op encodings and
// the transfer sequencing state.
package cpu_xfer_pkg;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    LATCH = 2'b10,
    DONE  = 2'b11
  } xfer_state_t;

  // Ops that end in a register write (or clear) during LATCH.
  function automatic logic op_writes(input logic [1:0] op);
    return (op != OP_NOP);
  endfunction

  // Ops that put a value on the shared bus during DRIVE/LATCH.
  function automatic logic op_drives_bus(input logic [1:0] op);
    return (op == OP_MOV) || (op == OP_LDI);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational; the priority pointer
// is owned by the caller. rr selects the winner only when both request.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // Single requester wins outright; a tie is broken by the pointer.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = rr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Index of the granted requester (0 when nothing is granted).
  always_comb begin
    gnt_id = gnt[1];
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer controller: arbitrates fetch/execute transfer commands
// and sequences the shared bus and register En/CLR strobes so each accepted
// command becomes exactly one register write or clear.
module reg_xfer_ctrl
  import cpu_xfer_pkg::*;
#(
  parameter int unsigned NREG = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned IW   = $clog2(NREG)
) (
  input  logic                 CLK,
  input  logic                 CLR_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [1:0][1:0]      req_op,
  input  logic [1:0][IW-1:0]   req_src,
  input  logic [1:0][IW-1:0]   req_dst,
  input  logic [1:0][W-1:0]    req_imm,
  output logic                 bus_oe,
  output logic                 bus_imm_sel,
  output logic [IW-1:0]        bus_src,
  output logic [W-1:0]         bus_imm,
  output logic [NREG-1:0]      reg_en,
  output logic                 reg_clr,
  output logic                 busy,
  output logic                 done,
  output logic                 done_id
);

  xfer_state_t   state_q, state_d;
  logic          rr_q, rr_d;
  logic [1:0]    op_q, op_d;
  logic [IW-1:0] src_q, src_d;
  logic [IW-1:0] dst_q, dst_d;
  logic [W-1:0]  imm_q, imm_d;
  logic          gid_q, gid_d;

  logic [1:0]    gnt;
  logic          gnt_id;
  logic          hs;
  logic          bus_phase;

  rr_arb2 u_arb (
    .req    (req_valid),
    .rr     (rr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // Grant is only offered from IDLE, and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE) begin
      req_ready = gnt & {2{CLR_n}};
    end
  end

  always_comb begin
    hs = |(req_valid & req_ready);
  end

  // State, pointer and captured command registers.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      op_q    <= OP_MOV;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= '0;
      gid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      gid_q   <= gid_d;
    end
  end

  // Next-state sequencing and command capture at handshake.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    gid_d   = gid_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          op_d    = req_op[gnt_id];
          src_d   = req_src[gnt_id];
          dst_d   = req_dst[gnt_id];
          imm_d   = req_imm[gnt_id];
          gid_d   = gnt_id;
          state_d = DRIVE;
        end
      end
      DRIVE: state_d = LATCH;
      LATCH: state_d = DONE;
      DONE: begin
        rr_d    = ~gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus_phase = (state_q == DRIVE) || (state_q == LATCH);
  end

  // Output decode from registered state and captured command.
  always_comb begin
    bus_oe      = 1'b0;
    bus_imm_sel = 1'b0;
    bus_src     = '0;
    bus_imm     = '0;
    reg_en      = '0;
    reg_clr     = 1'b0;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    done_id     = 1'b0;
    if (bus_phase && op_drives_bus(op_q)) begin
      bus_oe = 1'b1;
      if (op_q == OP_LDI) begin
        bus_imm_sel = 1'b1;
        bus_imm     = imm_q;
      end else begin
        bus_src = src_q;
      end
    end
    if ((state_q == LATCH) && op_writes(op_q)) begin
      // An out-of-range dst matches no bit, so the command completes silently.
      for (int unsigned i = 0; i < NREG; i++) begin
        if (32'(dst_q) == i) begin
          reg_en[i] = 1'b1;
        end
      end
      reg_clr = (op_q == OP_CLR);
    end
    if (state_q == DONE) begin
      done    = 1'b1;
      done_id = gid_q;
    end
  end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl with a behavioural register bank hung on
// the bus/enable outputs.
module tb_reg_xfer_ctrl;
  import cpu_xfer_pkg::*;

  localparam int unsigned NREG = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned IW   = 2;

  logic                CLK = 1'b0;
  logic                CLR_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][1:0]     req_op;
  logic [1:0][IW-1:0]  req_src;
  logic [1:0][IW-1:0]  req_dst;
  logic [1:0][W-1:0]   req_imm;
  logic                bus_oe;
  logic                bus_imm_sel;
  logic [IW-1:0]       bus_src;
  logic [W-1:0]        bus_imm;
  logic [NREG-1:0]     reg_en;
  logic                reg_clr;
  logic                busy;
  logic                done;
  logic                done_id;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] bank [NREG];
  logic [W-1:0] bus_val;

  reg_xfer_ctrl #(.NREG(NREG), .W(W)) dut (
    .CLK         (CLK),
    .CLR_n       (CLR_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src     (req_src),
    .req_dst     (req_dst),
    .req_imm     (req_imm),
    .bus_oe      (bus_oe),
    .bus_imm_sel (bus_imm_sel),
    .bus_src     (bus_src),
    .bus_imm     (bus_imm),
    .reg_en      (reg_en),
    .reg_clr     (reg_clr),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id)
  );

  always #5 CLK = ~CLK;

  // Register bank: not reset by CLR_n, captures on En, clears with CLR.
  always_comb bus_val = bus_imm_sel ? bus_imm : bank[bus_src];

  always @(posedge CLK) begin
    for (int i = 0; i < NREG; i++) begin
      if (reg_en[i]) bank[i] <= reg_clr ? '0 : bus_val;
    end
  end

  task automatic set_req(input int id, input logic [1:0] op, input logic [IW-1:0] src,
                         input logic [IW-1:0] dst, input logic [W-1:0] imm);
    req_op[id]  = op;
    req_src[id] = src;
    req_dst[id] = dst;
    req_imm[id] = imm;
    req_valid[id] = 1'b1;
  endtask

  // Runs one req0 LDI to completion from IDLE (stimulus only).
  task automatic load(input logic [IW-1:0] dst, input logic [W-1:0] imm);
    set_req(0, OP_LDI, '0, dst, imm);
    @(negedge CLK);
    req_valid = 2'b00;
    repeat (3) @(negedge CLK);
    #1;
  endtask

  task automatic test_reset;
    CLR_n = 1'b0;
    req_valid = 2'b11;
    req_op = '0; req_src = '0; req_dst = '0; req_imm = '0;
    @(negedge CLK); #1;
    total++;
    if ({req_ready, bus_oe, bus_imm_sel, bus_src, bus_imm, reg_en, reg_clr, busy, done, done_id} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ready=%b oe=%b sel=%b src=%h imm=%h en=%b clr=%b busy=%b done=%b id=%b exp all 0",
               req_ready, bus_oe, bus_imm_sel, bus_src, bus_imm, reg_en, reg_clr, busy, done, done_id);
    end
    req_valid = 2'b00;
    @(negedge CLK);
    CLR_n = 1'b1;
    @(negedge CLK); #1;
  endtask

  task automatic test_ldi;
    set_req(0, OP_LDI, 2'd0, 2'd1, 8'hA5); #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL ldi_ready got=%b exp=01", req_ready); end
    @(negedge CLK); req_valid = 2'b00; #1;
    for (int c = 1; c <= 2; c++) begin
      total++;
      if (bus_oe !== 1'b1 || bus_imm_sel !== 1'b1 || bus_imm !== 8'hA5) begin
        bad++; $display("FAIL ldi_bus c%0d got oe=%b sel=%b imm=%h exp 1 1 a5", c, bus_oe, bus_imm_sel, bus_imm);
      end
      total++;
      if (reg_en !== ((c == 2) ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL ldi_en c%0d got=%b", c, reg_en);
      end
      @(negedge CLK); #1;
    end
    total++;
    if (done !== 1'b1 || done_id !== 1'b0 || reg_en !== 4'b0 || bus_oe !== 1'b0) begin
      bad++; $display("FAIL ldi_done got done=%b id=%b en=%b oe=%b exp 1 0 0000 0", done, done_id, reg_en, bus_oe);
    end
    total++;
    if (bank[1] !== 8'hA5) begin bad++; $display("FAIL ldi_r1 got=%h exp=a5", bank[1]); end
    @(negedge CLK); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL ldi_idle got busy=%b done=%b exp 0 0", busy, done); end
  endtask

  task automatic test_mov;
    set_req(1, OP_MOV, 2'd1, 2'd3, 8'h00); #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL mov_ready got=%b exp=10", req_ready); end
    @(negedge CLK); req_valid = 2'b00; #1;
    for (int c = 1; c <= 2; c++) begin
      total++;
      if (bus_oe !== 1'b1 || bus_imm_sel !== 1'b0 || bus_src !== 2'd1) begin
        bad++; $display("FAIL mov_bus c%0d got oe=%b sel=%b src=%0d exp 1 0 1", c, bus_oe, bus_imm_sel, bus_src);
      end
      total++;
      if (reg_en !== ((c == 2) ? 4'b1000 : 4'b0000)) begin
        bad++; $display("FAIL mov_en c%0d got=%b", c, reg_en);
      end
      @(negedge CLK); #1;
    end
    total++;
    if (done !== 1'b1 || done_id !== 1'b1) begin bad++; $display("FAIL mov_done got done=%b id=%b exp 1 1", done, done_id); end
    total++;
    if (bank[3] !== 8'hA5) begin bad++; $display("FAIL mov_r3 got=%h exp=a5", bank[3]); end
    @(negedge CLK); #1;
  endtask

  task automatic test_clr;
    load(2'd0, 8'hFF);
    total++;
    if (bank[0] !== 8'hFF) begin bad++; $display("FAIL clr_preload got=%h exp=ff", bank[0]); end
    set_req(0, OP_CLR, 2'd0, 2'd0, 8'h00); #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL clr_ready got=%b exp=01", req_ready); end
    @(negedge CLK); req_valid = 2'b00; #1;
    for (int c = 1; c <= 3; c++) begin
      total++;
      if (bus_oe !== 1'b0) begin bad++; $display("FAIL clr_oe c%0d got=%b exp=0", c, bus_oe); end
      if (c == 2) begin
        total++;
        if (reg_en !== 4'b0001 || reg_clr !== 1'b1) begin
          bad++; $display("FAIL clr_latch got en=%b clr=%b exp 0001 1", reg_en, reg_clr);
        end
      end
      if (c < 3) begin @(negedge CLK); #1; end
    end
    total++;
    if (bank[0] !== 8'h00 || done !== 1'b1) begin bad++; $display("FAIL clr_r0 got r0=%h done=%b exp 00 1", bank[0], done); end
    @(negedge CLK); #1;
  endtask

  task automatic test_pulse_busy;
    set_req(0, OP_LDI, 2'd0, 2'd3, 8'h77); #1;
    @(negedge CLK); req_valid = 2'b00;
    set_req(1, OP_MOV, 2'd0, 2'd2, 8'h00); #1;
    total++;
    if (req_ready !== 2'b00 || busy !== 1'b1) begin
      bad++; $display("FAIL pulse_ready got ready=%b busy=%b exp 00 1", req_ready, busy);
    end
    @(negedge CLK); req_valid = 2'b00; #1;
    @(negedge CLK); #1;
    total++;
    if (done !== 1'b1 || done_id !== 1'b0 || bank[3] !== 8'h77) begin
      bad++; $display("FAIL pulse_done got done=%b id=%b r3=%h exp 1 0 77", done, done_id, bank[3]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL pulse_idle c%0d got busy=%b done=%b exp 0 0", c, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid;
    load(2'd2, 8'h11);
    set_req(0, OP_LDI, 2'd0, 2'd2, 8'h5A); #1;
    @(negedge CLK); req_valid = 2'b00;
    @(negedge CLK); #1;
    total++;
    if (reg_en !== 4'b0100) begin bad++; $display("FAIL rmid_latch got en=%b exp 0100", reg_en); end
    CLR_n = 1'b0; #1;
    total++;
    if ({req_ready, bus_oe, bus_imm_sel, bus_src, bus_imm, reg_en, reg_clr, busy, done, done_id} !== '0) begin
      bad++; $display("FAIL rmid_outputs got oe=%b sel=%b imm=%h en=%b busy=%b done=%b exp all 0",
                      bus_oe, bus_imm_sel, bus_imm, reg_en, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); #1;
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL rmid_nodone c%0d got=%b exp=0", c, done); end
    end
    total++;
    if (bank[2] !== 8'h11) begin bad++; $display("FAIL rmid_r2 got=%h exp=11", bank[2]); end
    CLR_n = 1'b1;
    @(negedge CLK); #1;
  endtask

  task automatic test_fairness;
    int left0 = 6;
    int left1 = 6;
    logic [1:0] exp_g;
    set_req(0, OP_NOP, 2'd0, 2'd0, 8'h00);
    set_req(1, OP_NOP, 2'd0, 2'd1, 8'h00);
    #1;
    for (int t = 0; t < 12; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (req_ready !== exp_g || done !== 1'b0) begin
        bad++; $display("FAIL fair_gnt t%0d got ready=%b done=%b exp %b 0", t, req_ready, done, exp_g);
      end
      @(negedge CLK);
      if (exp_g[0]) left0--; else left1--;
      req_valid = {(left1 != 0), (left0 != 0)};
      #1;
      for (int c = 1; c <= 2; c++) begin
        total++;
        if (reg_en !== 4'b0 || busy !== 1'b1 || done !== 1'b0) begin
          bad++; $display("FAIL fair_mid t%0d c%0d got en=%b busy=%b done=%b", t, c, reg_en, busy, done);
        end
        @(negedge CLK); #1;
      end
      total++;
      if (done !== 1'b1 || done_id !== exp_g[1] || reg_en !== 4'b0) begin
        bad++; $display("FAIL fair_done t%0d got done=%b id=%b en=%b exp 1 %b 0000", t, done, done_id, reg_en, exp_g[1]);
      end
      @(negedge CLK); #1;
    end
    total++;
    if (busy !== 1'b0 || req_valid !== 2'b00) begin bad++; $display("FAIL fair_end got busy=%b", busy); end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_mov();
    test_clr();
    test_pulse_busy();
    test_reset_mid();
    test_fairness();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/reg_xfer_ctrl.md
# reg_xfer_ctrl

Register-transfer controller for the mini 8-bit CPU datapath. Accepts transfer commands from two requesters (fetch unit = 0, execute unit = 1) and round-robin arbitrates between them. It sequences the shared 8-bit bus and the per-register enable/clear lines of the `Reg8Bit` bank, so each granted command becomes exactly one register write (or clear). Sits between the control units and the register bank; it owns the bus-source mux select and all register `En`/`CLR` strobes.

## Interface
- `NREG`, 4: number of registers in the bank (2..8); `IW = $clog2(NREG)`.
- `W`, 8: data width of immediate/bus.
- `CLK` in 1: system clock, rising edge.
- `CLR_n` in 1: asynchronous, active-low reset.
- `req_valid` in 2: per-requester command valid.
- `req_ready` out 2: per-requester accept; handshake = valid & ready in the same cycle.
- `req_op` in 2x2: op per requester; 00 MOV, 01 LDI, 10 CLR, 11 NOP.
- `req_src` in 2xIW: source register index (MOV only).
- `req_dst` in 2xIW: destination register index.
- `req_imm` in 2xW: immediate (LDI only).
- `bus_oe` out 1: bus driven this cycle.
- `bus_imm_sel` out 1: 1 = bus carries `bus_imm`; 0 = bus carries register `bus_src`.
- `bus_src` out IW: register read-mux select.
- `bus_imm` out W: immediate value to the bus.
- `reg_en` out NREG: one-hot register enable (maps to `Reg8Bit.En`).
- `reg_clr` out 1: shared clear (maps to `Reg8Bit.CLR`; effective only with `reg_en`).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `done_id` out 1: requester whose command completed; valid when `done`=1.

## Operation
- States: IDLE -> DRIVE -> LATCH -> DONE -> IDLE.
- IDLE:
  - Only state with `req_ready` possible. Grant is combinational.
  - One valid -> grant it. Both valid -> grant `rr`.
  - `req_ready[g]`=1 for the grantee only.
  - On handshake, capture op/src/dst/imm and `g`; go to DRIVE.
  - No valid -> stay in IDLE.
- DRIVE:
  - MOV: `bus_oe`=1, `bus_imm_sel`=0, `bus_src`=src.
  - LDI: `bus_oe`=1, `bus_imm_sel`=1, `bus_imm`=imm.
  - CLR/NOP: `bus_oe`=0.
  - `reg_en`=0 for all ops. This is the bus settle cycle.
- LATCH:
  - Bus outputs held as in DRIVE.
  - MOV/LDI/CLR: `reg_en[dst]`=1. CLR also drives `reg_clr`=1.
  - NOP: `reg_en`=0.
  - The register captures on the rising edge that ends LATCH.
- DONE:
  - `done`=1, `done_id`=g. Bus released (`bus_oe`=0), `reg_en`=0, `reg_clr`=0.
  - `rr` <= ~g. Go to IDLE.
- `dst` >= NREG (non-power-of-2 NREG): no `reg_en` bit asserted; the command still completes with `done`.
- MOV with src==dst: legal. The register reloads its own value.
- `req_valid` may drop before handshake with no effect. Command fields are sampled only at handshake.
- Requests arriving while `busy` wait with `req_ready`=0. No queueing inside the block.

## Timing
- Reset (`CLR_n`=0, async):
  - State IDLE, `rr`=0.
  - All outputs 0: `req_ready`, `bus_*`, `reg_en`, `reg_clr`, `busy`, `done`, `done_id`.
  - A transfer in flight is abandoned: no `done`, no register write after reset asserts.
- Latency for a handshake at edge k:
  - DRIVE in cycle k+1, LATCH in cycle k+2.
  - Register updated at edge k+3.
  - `done` is high in cycle k+3.
  - IDLE in cycle k+4, which is the earliest next handshake.
- Throughput: one transfer per 4 cycles.
- All outputs except `req_ready` are registered-state decodes. `req_ready` is combinational from `req_valid`, state and `rr`.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

## Structure
- Package `cpu_xfer_pkg`:
  - Op encoding constants `OP_MOV`, `OP_LDI`, `OP_CLR`, `OP_NOP`.
  - State enum `xfer_state_t` {IDLE, DRIVE, LATCH, DONE}.
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: `req[1:0]`, `rr`.
  - Outputs: `gnt[1:0]` one-hot and `gnt_id`.
  - Purely combinational. The `rr` register lives in `reg_xfer_ctrl`.

## Test plan
- Reset mid-LATCH of an LDI 0x5A -> dst 2.
  - Required: all outputs 0 immediately; R2 unchanged; no `done`; next command accepted from IDLE with `rr`=0.
- Req0 LDI imm=0xA5 dst=1.
  - Required: `req_ready[0]` in cycle 0; `bus_imm_sel`=1 and `bus_imm`=0xA5 in cycles 1–2; `reg_en`=0010 in cycle 2 only; R1=0xA5 after edge 3; `done`=1, `done_id`=0 in cycle 3.
- Then req1 MOV src=1 dst=3.
  - Required: `bus_src`=1 in cycles 1–2; `reg_en`=1000 in cycle 2; R3=0xA5; `done_id`=1.
- Both requesters valid continuously, 6 NOPs each, starting from reset.
  - Required: grant order 0,1,0,1,0,1…; `reg_en` never asserted; `done` every 4th cycle.
- Req0 CLR dst=0 with R0=0xFF.
  - Required: `bus_oe`=0 throughout; `reg_en`=0001 with `reg_clr`=1 in LATCH; R0=0x00 after.
- `req_valid[1]` pulsed for one cycle while `busy`, then dropped.
  - Required: no handshake and no transfer for req1; the in-flight command completes normally.
